aes_key_sync_source: RTL
========================

Name: aes_key_sync_source

Overview:
- Master-side producer of key/sync pairs for the AES counter-mode datapath; drives the DVR key_and_sync channel that the counter-mode top consumes as a slave.
- Holds a software-loaded key and a 64-bit salt.
- On each request, issues one {key, sync} pair whose sync is unique under the current key: sync = {salt, session_id, 32'h0}.
- Stops issuing pairs once session_id space is exhausted, so a key/sync pair is never reused.

Parameters:
- BLOCK_W, 128, AES block/key width in bits
- SALT_W, 64, salt width; sync upper field
- SID_W, 32, session_id width; BLOCK_W = SALT_W + SID_W + 32 must hold (elaboration error otherwise)
- REQ_DEPTH, 4, maximum outstanding session requests

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- key_in  input  BLOCK_W  key to load
- salt_in  input  SALT_W  salt to load
- key_load  input  1  one-cycle pulse; captures key_in/salt_in
- session_req  input  1  one-cycle pulse; request one key/sync pair
- key_and_sync_out  dvr_if.master  2*BLOCK_W  data = {key[BLOCK_W-1:0], sync[BLOCK_W-1:0]} (key in upper half), valid, ready
- key_loaded  output  1  a key is active
- exhausted  output  1  session_id space used up; cleared by key_load
- req_overflow  output  1  one-cycle pulse; session_req dropped (queue full)
- pending  output  $clog2(REQ_DEPTH+1)  outstanding requests

Behaviour:
- Reset: async assert on rst=0; release sync to clk. On reset: state=NO_KEY; valid=0; data=0; key_loaded=0; exhausted=0; req_overflow=0; pending=0; session_id=0; shadow regs cleared.
- States:
  - NO_KEY: valid=0; requests are still queued. key_load -> IDLE.
  - IDLE: valid=0. pending>0 -> OFFER next cycle.
  - OFFER: valid=1; data is registered and stable while valid & !ready.
  - EXHAUSTED: valid=0; exhausted=1.
- Handshake: completes on valid & ready. session_id increments on every handshake.
  - After handshake with pending>1: stay in OFFER. Next cycle presents the next session_id, back-to-back (one pair per cycle max).
  - After handshake with pending=1: -> IDLE.
- Latency: session_req in cycle N while IDLE with active key -> valid=1 in cycle N+1.
- Pending counter:
  - +1 on session_req; -1 on handshake; simultaneous req and handshake -> unchanged.
  - session_req with pending=REQ_DEPTH and no handshake in the same cycle -> request dropped; req_overflow=1 next cycle.
  - Requests are preserved across key_load and EXHAUSTED.
- Exhaustion: a handshake with session_id = 2^SID_W-1 -> EXHAUSTED. session_id wraps to 0 only on a key change.
- key_load:
  - In NO_KEY, IDLE or EXHAUSTED: apply next cycle. key/salt <= inputs; session_id <= 0; exhausted <= 0; key_loaded <= 1; state -> OFFER if pending>0, else IDLE.
  - During OFFER: captured into shadow regs, flagged. Applied in the cycle after the current handshake completes; the pair in flight keeps the old key. The next offer uses the new key with session_id=0.
  - A second key_load before apply overwrites the shadow.
  - key_load coincident with a handshake: the handshake pair is old-key; the new key is applied next cycle.
- Sync arithmetic: sync[BLOCK_W-1 -: SALT_W] = salt; next SID_W bits = session_id; low 32 bits = 0 (consumer increments these per block).
- Reset mid-OFFER: valid drops immediately (async); the pair is lost; the key must be reloaded.

Test Plan:
- Reset; key_load key=0x000102..0F, salt=0xA5A5A5A5_5A5A5A5A; session_req; ready=1 -> valid at N+1. data = {key, 0xA5A5A5A5_5A5A5A5A_00000000_00000000}; pending 1->0.
- Four back-to-back session_req; ready=0 for 5 cycles, then 1 -> data stable while stalled. Then 4 consecutive handshakes with session_id 0,1,2,3. A fifth req while pending=4 -> req_overflow pulse, pending stays 4.
- session_req before any key_load -> no valid. key_load 3 cycles later -> valid with session_id=0.
- Force session_id=2^SID_W-2; two requests -> ids 0xFFFFFFFE and 0xFFFFFFFF issued; exhausted=1; third request held (pending=1). key_load -> offer with session_id=0; exhausted=0.
- key_load while OFFER with ready=0 -> in-flight data keeps the old key. After ready, the next pair carries the new key/salt with session_id=0.
- Assert rst=0 mid-OFFER -> valid=0 in the same cycle; key_loaded=0, pending=0; no valid until key_load plus session_req.

Source files
------------

// File: rtl/aes_key_sync_source_if.sv
// -----------------------------------------------------------------------------
// dvr_if: data/valid/ready channel.
//   data  : W-bit payload, driven by the master
//   valid : master has a payload on data
//   ready : slave accepts the payload; a transfer completes on valid & ready
// -----------------------------------------------------------------------------
interface dvr_if #(
    parameter int W = 256
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface : dvr_if

// File: rtl/aes_key_sync_source.sv
// -----------------------------------------------------------------------------
// aes_key_sync_source
//   Master-side producer of {key, sync} pairs for the AES counter-mode
//   datapath. Software loads a key and a salt; every session request yields
//   one pair whose sync is unique under the current key:
//       sync = {salt, session_id, 32'h0}
//   Once the session_id space is used up the block stops issuing pairs until
//   a new key is loaded, so a key/sync pair is never reused.
//
// Ports
//   clk              : clock
//   rst              : asynchronous active-low reset (release synchronised)
//   key_in           : key to load
//   salt_in          : salt to load
//   key_load         : one-cycle pulse, captures key_in/salt_in
//   session_req      : one-cycle pulse, requests one key/sync pair
//   key_and_sync_out : dvr master, data = {key, sync} (key in upper half)
//   key_loaded       : a key is active
//   exhausted        : session_id space used up; cleared by key_load
//   req_overflow     : one-cycle pulse, a session_req was dropped (queue full)
//   pending          : outstanding requests
// -----------------------------------------------------------------------------
module aes_key_sync_source #(
    parameter int BLOCK_W   = 128,
    parameter int SALT_W    = 64,
    parameter int SID_W     = 32,
    parameter int REQ_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BLOCK_W-1:0]                 key_in,
    input  logic [SALT_W-1:0]                  salt_in,
    input  logic                               key_load,
    input  logic                               session_req,
    dvr_if.master                              key_and_sync_out,
    output logic                               key_loaded,
    output logic                               exhausted,
    output logic                               req_overflow,
    output logic [$clog2(REQ_DEPTH+1)-1:0]     pending
);

    localparam int PEND_W = $clog2(REQ_DEPTH + 1);
    localparam logic [SID_W-1:0] SID_MAX = '1;

    // The sync word must exactly hold salt, session_id and the 32-bit block
    // counter that the consumer increments.
    if (BLOCK_W != SALT_W + SID_W + 32) begin : g_bad_widths
        $error("aes_key_sync_source: BLOCK_W must equal SALT_W + SID_W + 32");
    end

    typedef enum logic [1:0] {
        ST_NO_KEY    = 2'd0,
        ST_IDLE      = 2'd1,
        ST_OFFER     = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge so that no flop
    // sees a reset deassertion close to its sampling edge.
    // -------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [BLOCK_W-1:0] r_key;
    logic [SALT_W-1:0]  r_salt;
    logic [SID_W-1:0]   r_session_id;
    logic               r_key_loaded;
    logic               r_req_overflow;
    logic [PEND_W-1:0]  r_pending;
    logic [BLOCK_W-1:0] r_shadow_key;
    logic [SALT_W-1:0]  r_shadow_salt;
    logic               r_shadow_valid;

    logic               w_hs;
    logic               w_req_accept;
    logic               w_overflow;
    logic [PEND_W-1:0]  w_pending_next;
    logic               w_has_work;
    logic               w_apply;
    logic [BLOCK_W-1:0] w_new_key;
    logic [SALT_W-1:0]  w_new_salt;

    assign w_hs = (r_state == ST_OFFER) && key_and_sync_out.ready;

    // A full queue can still take a request in the cycle a handshake frees a
    // slot; otherwise the request is dropped and flagged.
    assign w_req_accept   = session_req && ((r_pending != PEND_W'(REQ_DEPTH)) || w_hs);
    assign w_overflow     = session_req && !w_req_accept;
    assign w_pending_next = r_pending + PEND_W'(w_req_accept) - PEND_W'(w_hs);
    assign w_has_work     = (w_pending_next != '0);

    // A new key takes effect at this edge when no pair is on offer, or when
    // the pair on offer completes now (it was already presented with the old
    // key). A key_load in the same cycle is newer than the shadow copy.
    assign w_apply    = key_load ? ((r_state != ST_OFFER) || w_hs)
                                 : (w_hs && r_shadow_valid);
    assign w_new_key  = key_load ? key_in  : r_shadow_key;
    assign w_new_salt = key_load ? salt_in : r_shadow_salt;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            ST_NO_KEY, ST_EXHAUSTED: begin
                if (w_apply) begin
                    w_state_next = w_has_work ? ST_OFFER : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_apply || w_has_work) begin
                    w_state_next = w_has_work ? ST_OFFER : ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (w_hs) begin
                    if (w_apply) begin
                        w_state_next = w_has_work ? ST_OFFER : ST_IDLE;
                    end else if (r_session_id == SID_MAX) begin
                        // Last id under this key just went out.
                        w_state_next = ST_EXHAUSTED;
                    end else begin
                        w_state_next = w_has_work ? ST_OFFER : ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_NO_KEY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            // NOTE: the shadow key registers are reset along with everything
            // else so no stale key material survives a reset.
            r_state        <= ST_NO_KEY;
            r_key          <= '0;
            r_salt         <= '0;
            r_session_id   <= '0;
            r_key_loaded   <= 1'b0;
            r_req_overflow <= 1'b0;
            r_pending      <= '0;
            r_shadow_key   <= '0;
            r_shadow_salt  <= '0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pending      <= w_pending_next;
            r_req_overflow <= w_overflow;

            if (w_apply) begin
                r_key          <= w_new_key;
                r_salt         <= w_new_salt;
                r_session_id   <= '0;
                r_key_loaded   <= 1'b1;
                r_shadow_valid <= 1'b0;
            end else begin
                // The id stays at its maximum after the last handshake; it
                // only returns to zero with a new key.
                if (w_hs && (r_session_id != SID_MAX)) begin
                    r_session_id <= r_session_id + SID_W'(1);
                end
                // Only reachable while a pair is on offer and not completing:
                // hold the new key until the current pair is taken.
                if (key_load) begin
                    r_shadow_key   <= key_in;
                    r_shadow_salt  <= salt_in;
                    r_shadow_valid <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The payload is built only from registers, so it is stable for
    // as long as valid is held without ready.
    // -------------------------------------------------------------------------
    assign key_and_sync_out.valid = (r_state == ST_OFFER);
    assign key_and_sync_out.data  = {r_key, r_salt, r_session_id, 32'h0};

    assign key_loaded   = r_key_loaded;
    assign exhausted    = (r_state == ST_EXHAUSTED);
    assign req_overflow = r_req_overflow;
    assign pending      = r_pending;

endmodule : aes_key_sync_source
